chan_sel_ctrl: RTL
==================

Name: chan_sel_ctrl

Overview:
- Parametrised sequential successor to the combinational channel-decode/increment control benchmarks in the suite.
- Decodes an SEL_W-bit channel select into a one-hot grant and holds it through a request/acknowledge handshake.
- Keeps a CNT_W-bit loadable grant counter with wrap flag, standing in for the carry-chain outputs of the older blocks.
- Used as a small FSM-plus-datapath benchmark for FPGA mapping flows.

Parameters:
- SEL_W, 3, channel-select width; NCH = 2**SEL_W channels.
- CNT_W, 7, grant counter width.
- TIMEOUT, 15, GRANT-state cycle limit (used only with the optional feature); must be < 2**8.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  global enable; when low the FSM holds state and the counter holds.
- req  input  1  request strobe, sampled in IDLE.
- sel  input  SEL_W  channel select, captured with req.
- chan_busy  input  NCH  per-channel busy; a busy channel cannot be granted.
- ack  input  1  acknowledge from the granted channel.
- cnt_load  input  1  synchronous counter load.
- cnt_din  input  CNT_W  counter load value.
- grant  output  NCH  one-hot registered grant; all zero when not in GRANT.
- grant_vld  output  1  high exactly while in GRANT.
- rej  output  1  one-cycle pulse when a request is rejected because the channel is busy.
- cnt_q  output  CNT_W  grant counter.
- cnt_wrap  output  1  one-cycle pulse when the counter wraps all-ones to zero.
- st  output  2  current state encoding, for observability.

Behaviour:
- Reset values: st=IDLE(0), grant=0, grant_vld=0, rej=0, cnt_q=0, cnt_wrap=0.
- Reset has priority over every other input and aborts any operation in progress.
- States: IDLE=0, CHECK=1, GRANT=2, DONE=3.
- IDLE: on en&req, capture sel into sel_r and go to CHECK; otherwise stay.
- CHECK (1 cycle):
  - If chan_busy[sel_r], pulse rej and go to IDLE.
  - Otherwise set grant=1<<sel_r, set grant_vld=1, go to GRANT.
  - chan_busy is sampled only in CHECK.
- GRANT: hold grant. On en&ack, clear grant and grant_vld, go to DONE. ack outside GRANT is ignored.
- DONE (1 cycle):
  - cnt_q increments by 1 modulo 2**CNT_W.
  - On the all-ones to 0 transition, cnt_wrap pulses in the same cycle cnt_q shows 0.
  - Then go to IDLE.
- Latency: req to grant is 2 edges (IDLE→CHECK→GRANT). Minimum full transaction is 4 cycles with ack asserted immediately.
- en low: all state, grant and counter frozen; rej and cnt_wrap forced to 0 that cycle. Load is also blocked.
- Counter load:
  - cnt_load&en overrides the DONE increment: the loaded value wins and no wrap pulse is generated.
  - Loads are accepted in any state.
- req while not in IDLE is ignored; there is no queueing.

Optional Feature:
- Macro: CHAN_SEL_CTRL_TIMEOUT_EN.
- Defined:
  - An 8-bit timer clears on entry to GRANT and counts enabled cycles in GRANT.
  - When the timer reaches TIMEOUT without ack, grant is dropped, a one-cycle to_err pulse is raised (extra output port, 1 bit, reset 0), and the FSM returns to IDLE without incrementing the counter.
  - ack in the same cycle as timeout wins: normal DONE path, no to_err.
- Undefined: no timer and no to_err port; GRANT waits indefinitely.

Decomposition:
- Package chan_sel_ctrl_pkg holds:
  - state enum (ST_IDLE, ST_CHECK, ST_GRANT, ST_DONE) with 2-bit encoding;
  - default parameter constants;
  - the timer width constant.
- One sub-module, chan_sel_cnt: loadable wrapping counter with en/load/inc/wrap.
- The FSM and decode stay in the top.

Test Plan:
- Reset then idle: after reset, hold req=0 for 5 cycles -> grant=0, st=0, cnt_q=0 throughout.
- Basic grant, SEL_W=3: req=1, sel=5, chan_busy=0 -> grant=8'b0010_0000 on the 2nd edge. ack 3 cycles later -> grant=0, cnt_q=1 after DONE.
- Busy reject: chan_busy=8'h04, req with sel=2 -> rej pulses 1 cycle in CHECK, grant stays 0, cnt_q unchanged.
- Wrap and load priority:
  - cnt_load with cnt_din=7'h7F, then one full transaction -> cnt_q=0, cnt_wrap pulses once.
  - Repeat with cnt_load=1, cnt_din=7'h10 during DONE -> cnt_q=7'h10, no wrap.
- Enable freeze and mid-op reset:
  - Drop en for 4 cycles while in GRANT -> all outputs frozen, ack ignored.
  - Assert reset in GRANT -> next edge grant=0, st=0, cnt_q=0.
- With CHAN_SEL_CTRL_TIMEOUT_EN, TIMEOUT=15: no ack after grant -> to_err pulses 15 cycles into GRANT, grant drops, cnt_q unchanged. Ack on the timeout cycle -> no to_err, cnt_q increments.

Source files
------------

// File: rtl/chan_sel_ctrl_pkg.sv
// Shared types and defaults for the channel-select grant controller.
package chan_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_GRANT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int SEL_W_DEF   = 3;
    localparam int CNT_W_DEF   = 7;
    localparam int TIMEOUT_DEF = 15;
    localparam int TMR_W       = 8;

endpackage

// File: rtl/chan_sel_ctrl_if.sv
// Request/grant and counter bus of chan_sel_ctrl; to_err exists only with CHAN_SEL_CTRL_TIMEOUT_EN.
interface chan_sel_if
    import chan_sel_ctrl_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int NCH = 1 << SEL_W;

    logic             en;
    logic             req;
    logic [SEL_W-1:0] sel;
    logic [NCH-1:0]   chan_busy;
    logic             ack;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_din;
    logic [NCH-1:0]   grant;
    logic             grant_vld;
    logic             rej;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_wrap;
    logic [1:0]       st;
`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
    logic             to_err;
`endif

    modport master (
        output en, req, sel, chan_busy, ack, cnt_load, cnt_din,
        input  grant, grant_vld, rej, cnt_q, cnt_wrap, st
`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
        , input to_err
`endif
    );

    modport slave (
        input  en, req, sel, chan_busy, ack, cnt_load, cnt_din,
        output grant, grant_vld, rej, cnt_q, cnt_wrap, st
`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
        , output to_err
`endif
    );
endinterface

// File: rtl/chan_sel_ctrl_cnt.sv
// Loadable wrapping counter; load beats increment, wrap pulses with the all-ones to zero step.
// Latency: 1 cycle. Backpressure: en low freezes q and suppresses wrap.
module chan_sel_cnt #(
    parameter int W = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);
    always_ff @(posedge clock) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else if (load) begin
            q    <= din;
            wrap <= 1'b0;
        end else if (inc) begin
            q    <= q + 1'b1;
            wrap <= &q;
        end else begin
            wrap <= 1'b0;
        end
    end
endmodule

// File: rtl/chan_sel_ctrl.sv
// Channel-select grant FSM with grant counter; optional GRANT timeout via CHAN_SEL_CTRL_TIMEOUT_EN.
// Latency: req to grant 2 edges, minimum transaction 4 cycles; rej is combinational in CHECK.
// Backpressure: en low freezes all state and counter, masks rej/cnt_wrap/to_err.
module chan_sel_ctrl
    import chan_sel_ctrl_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic      clock,
    input  logic      reset,
    chan_sel_if.slave bus
);
    localparam int NCH = 1 << SEL_W;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_CHECK = ST_CHECK;
    localparam logic [1:0] S_GRANT = ST_GRANT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    if (TIMEOUT < 1 || TIMEOUT >= (1 << TMR_W)) begin : g_bad_timeout
        $error("chan_sel_ctrl: TIMEOUT out of range");
    end

    logic [1:0]       st_q;
    logic [SEL_W-1:0] sel_r;
    logic [NCH-1:0]   grant_q;
    logic             grant_vld_q;
    logic [NCH-1:0]   onehot;

    assign onehot = {{(NCH-1){1'b0}}, 1'b1} << sel_r;

`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    logic [TMR_W-1:0] timer_q;
    logic             to_err_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q        <= S_IDLE;
            sel_r       <= '0;
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
            timer_q     <= '0;
            to_err_q    <= 1'b0;
`endif
        end else if (bus.en) begin
`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
            to_err_q <= 1'b0;
`endif
            case (st_q)
                S_IDLE: begin
                    if (bus.req) begin
                        sel_r <= bus.sel;
                        st_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bus.chan_busy[sel_r]) begin
                        st_q <= S_IDLE;
                    end else begin
                        grant_q     <= onehot;
                        grant_vld_q <= 1'b1;
                        st_q        <= S_GRANT;
`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
                        timer_q     <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (bus.ack) begin
                        grant_q     <= '0;
                        grant_vld_q <= 1'b0;
                        st_q        <= S_DONE;
                    end
`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
                    else if (timer_q == TMR_LAST) begin
                        grant_q     <= '0;
                        grant_vld_q <= 1'b0;
                        to_err_q    <= 1'b1;
                        st_q        <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end
                default: st_q <= S_IDLE;
            endcase
        end
`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
        else begin
            to_err_q <= 1'b0;
        end
`endif
    end

    chan_sel_cnt #(.W(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .en    (bus.en),
        .load  (bus.cnt_load),
        .din   (bus.cnt_din),
        .inc   (st_q == S_DONE),
        .q     (bus.cnt_q),
        .wrap  (bus.cnt_wrap)
    );

    assign bus.grant     = grant_q;
    assign bus.grant_vld = grant_vld_q;
    assign bus.rej       = bus.en && (st_q == S_CHECK) && bus.chan_busy[sel_r];
    assign bus.st        = st_q;
`ifdef CHAN_SEL_CTRL_TIMEOUT_EN
    assign bus.to_err    = to_err_q;
`endif
endmodule
